// File: rtl/ascensor_pkg.sv
// ascensor_pkg: shared definitions between ALGORITMO and the car executor.
// Holds the command encoding, the executor state encoding and the default
// sizing constants. The FALLA state only exists when
// EJECUTOR_PISO_WATCHDOG_EN is defined.
package ascensor_pkg;

    // One-step command issued by the algorithm; encoding must match on both ends.
    typedef enum logic [1:0] {
        NADA  = 2'd0,
        SUBIR = 2'd1,
        BAJAR = 2'd2,
        ABRIR = 2'd3
    } cmd_t;

    // Executor states.
    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        SUBIENDO = 3'd1,
        BAJANDO  = 3'd2,
`ifdef EJECUTOR_PISO_WATCHDOG_EN
        PUERTA   = 3'd3,
        FALLA    = 3'd4
`else
        PUERTA   = 3'd3
`endif
    } estado_ejec_t;

    localparam int N_PISOS_DEF    = 4;
    localparam int T_PUERTA_DEF   = 50;
    localparam int T_WATCHDOG_DEF = 1000;

endpackage

// File: rtl/sincronizador_flanco.sv
// sincronizador_flanco: brings an asynchronous level into the clock domain
// through two flops, then flags its rising edge with a one-cycle pulse.
// The pulse is combinational off the synchronized stages so that the
// consumer's own register is the third and last stage of latency.
module sincronizador_flanco (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dato_i,
    output logic flanco_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= dato_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign flanco_o = sync2_q & ~prev_q;

endmodule

// File: rtl/ejecutor_piso.sv
// ejecutor_piso: motion and door executor for the elevator car.
// Accepts single-step commands (up, down, open door), drives motor and door,
// tracks the current floor from the shaft sensor and returns cambio_piso /
// esperar feedback to the algorithm.
// Optional: EJECUTOR_PISO_WATCHDOG_EN adds a motion watchdog, the FALLA
// state and the falla output; FALLA is left only through rst.
//
// state    | meaning
// ---------+------------------------------------------------------------
// REPOSO   | idle, cmd_ready=1, waiting for a command
// SUBIENDO | motor up, waiting for the next floor mark
// BAJANDO  | motor down, waiting for the next floor mark
// PUERTA   | door open, dwell counter running
// FALLA    | (watchdog build) no floor mark in time, motors off until rst
module ejecutor_piso
    import ascensor_pkg::*;
#(
    parameter int N_PISOS    = N_PISOS_DEF,
    parameter int T_PUERTA   = T_PUERTA_DEF,
    parameter int T_WATCHDOG = T_WATCHDOG_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    input  logic [1:0]                 cmd,
    output logic                       cmd_ready,
    input  logic                       sensor_piso,
    output logic                       motor_sub,
    output logic                       motor_baj,
    output logic                       puerta_abierta,
    output logic                       cambio_piso,
    output logic                       esperar,
    output logic [$clog2(N_PISOS)-1:0] piso_actual,
`ifdef EJECUTOR_PISO_WATCHDOG_EN
    output logic                       cmd_error,
    output logic                       falla
`else
    output logic                       cmd_error
`endif
);

    localparam int PW = $clog2(N_PISOS);
    localparam int DW = $clog2(T_PUERTA + 1);
    localparam logic [PW-1:0] PISO_TOPE  = PW'(N_PISOS - 1);
    localparam logic [DW-1:0] DWELL_CARGA = DW'(T_PUERTA - 1);

    // Elaboration-time sanity checks on the sizing parameters.
    if (N_PISOS < 2) begin : g_chk_pisos
        $error("ejecutor_piso: N_PISOS must be at least 2");
    end
    if (T_PUERTA < 1) begin : g_chk_puerta
        $error("ejecutor_piso: T_PUERTA must be at least 1");
    end
    if (T_WATCHDOG < 1) begin : g_chk_wd
        $error("ejecutor_piso: T_WATCHDOG must be at least 1");
    end

    estado_ejec_t  estado_q, estado_d;
    logic [PW-1:0] piso_q,   piso_d;
    logic [DW-1:0] dwell_q,  dwell_d;
    logic          cambio_q, cambio_d;
    logic          error_q,  error_d;
    logic          flanco;
    logic          aceptar;
    cmd_t          cmd_in;

`ifdef EJECUTOR_PISO_WATCHDOG_EN
    localparam int WW = $clog2(T_WATCHDOG + 1);
    localparam logic [WW-1:0] WD_LIMITE = WW'(T_WATCHDOG - 1);
    logic [WW-1:0] wd_q, wd_d;
`endif

    sincronizador_flanco u_sincronizador (
        .clk_i    (clk),
        .rst_i    (rst),
        .dato_i   (sensor_piso),
        .flanco_o (flanco)
    );

    assign cmd_in  = cmd_t'(cmd);
    assign aceptar = cmd_valid && cmd_ready;

    // State and data registers; reset aborts any motion or dwell at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= REPOSO;
            piso_q   <= '0;
            dwell_q  <= '0;
            cambio_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef EJECUTOR_PISO_WATCHDOG_EN
            wd_q     <= '0;
`endif
        end else begin
            estado_q <= estado_d;
            piso_q   <= piso_d;
            dwell_q  <= dwell_d;
            cambio_q <= cambio_d;
            error_q  <= error_d;
`ifdef EJECUTOR_PISO_WATCHDOG_EN
            wd_q     <= wd_d;
`endif
        end
    end

    // Next-state logic: command decode, floor tracking, dwell and watchdog.
    always_comb begin
        estado_d = estado_q;
        piso_d   = piso_q;
        dwell_d  = dwell_q;
        cambio_d = 1'b0;
        error_d  = 1'b0;
`ifdef EJECUTOR_PISO_WATCHDOG_EN
        wd_d     = wd_q;
`endif
        case (estado_q)
            REPOSO: begin
`ifdef EJECUTOR_PISO_WATCHDOG_EN
                wd_d = '0;
`endif
                if (aceptar) begin
                    case (cmd_in)
                        SUBIR: begin
                            if (piso_q < PISO_TOPE) estado_d = SUBIENDO;
                            else                    error_d  = 1'b1;
                        end
                        BAJAR: begin
                            if (piso_q != '0) estado_d = BAJANDO;
                            else              error_d  = 1'b1;
                        end
                        ABRIR: begin
                            estado_d = PUERTA;
                            dwell_d  = DWELL_CARGA;
                        end
                        default: ;
                    endcase
                end
            end
            SUBIENDO: begin
                if (flanco) begin
                    estado_d = REPOSO;
                    piso_d   = piso_q + PW'(1);
                    cambio_d = 1'b1;
                end
`ifdef EJECUTOR_PISO_WATCHDOG_EN
                else if (wd_q == WD_LIMITE) estado_d = FALLA;
                else                        wd_d     = wd_q + WW'(1);
`endif
            end
            BAJANDO: begin
                if (flanco) begin
                    estado_d = REPOSO;
                    piso_d   = piso_q - PW'(1);
                    cambio_d = 1'b1;
                end
`ifdef EJECUTOR_PISO_WATCHDOG_EN
                else if (wd_q == WD_LIMITE) estado_d = FALLA;
                else                        wd_d     = wd_q + WW'(1);
`endif
            end
            PUERTA: begin
                if (dwell_q == '0) estado_d = REPOSO;
                else               dwell_d  = dwell_q - DW'(1);
            end
`ifdef EJECUTOR_PISO_WATCHDOG_EN
            FALLA: estado_d = FALLA;
`endif
            default: estado_d = REPOSO;
        endcase
    end

    // Outputs decoded from the current state; pulses come from registers.
    always_comb begin
        cmd_ready      = 1'b0;
        motor_sub      = 1'b0;
        motor_baj      = 1'b0;
        puerta_abierta = 1'b0;
        esperar        = 1'b0;
`ifdef EJECUTOR_PISO_WATCHDOG_EN
        falla          = 1'b0;
`endif
        case (estado_q)
            REPOSO:   cmd_ready = 1'b1;
            SUBIENDO: motor_sub = 1'b1;
            BAJANDO:  motor_baj = 1'b1;
            PUERTA: begin
                puerta_abierta = 1'b1;
                esperar        = 1'b1;
            end
`ifdef EJECUTOR_PISO_WATCHDOG_EN
            FALLA:    falla = 1'b1;
`endif
            default: ;
        endcase
    end

    assign cambio_piso = cambio_q;
    assign cmd_error   = error_q;
    assign piso_actual = piso_q;

endmodule

// File: tb/tb_ejecutor_piso.sv
// Testbench for ejecutor_piso: directed commands with hand-computed results.
// cambio_piso and cmd_error events are predicted into a queue by the stimulus
// and checked by an independent monitor when the DUT pulses them.
module tb_ejecutor_piso;
    import ascensor_pkg::*;

    localparam int NP = 4;
    localparam int TP = 5;
    localparam int TW = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       sensor_piso;
    logic       motor_sub;
    logic       motor_baj;
    logic       puerta_abierta;
    logic       cambio_piso;
    logic       esperar;
    logic [1:0] piso_actual;
    logic       cmd_error;
`ifdef EJECUTOR_PISO_WATCHDOG_EN
    logic       falla;
`endif

    ejecutor_piso #(
        .N_PISOS    (NP),
        .T_PUERTA   (TP),
        .T_WATCHDOG (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd            (cmd),
        .cmd_ready      (cmd_ready),
        .sensor_piso    (sensor_piso),
        .motor_sub      (motor_sub),
        .motor_baj      (motor_baj),
        .puerta_abierta (puerta_abierta),
        .cambio_piso    (cambio_piso),
        .esperar        (esperar),
        .piso_actual    (piso_actual),
`ifdef EJECUTOR_PISO_WATCHDOG_EN
        .cmd_error      (cmd_error),
        .falla          (falla)
`else
        .cmd_error      (cmd_error)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit es_error;
        int piso;
    } esperado_t;

    esperado_t sb_q[$];

    task automatic chk(input string nombre, input int actual, input int req);
        checks++;
        if (actual != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, actual, req, $time);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pops on DUT pulses.
    initial begin
        esperado_t e;
        forever begin
            @(negedge clk);
            checks++;
            if ((motor_sub && motor_baj) || ((motor_sub || motor_baj) && puerta_abierta)) begin
                errors++;
                $display("FAIL invariant: motor_sub=%0b motor_baj=%0b puerta=%0b expected no overlap",
                         motor_sub, motor_baj, puerta_abierta);
            end
            if (cambio_piso) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected cambio_piso: got pulse expected none (piso=%0d t=%0t)",
                             piso_actual, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("event kind at cambio_piso", int'(e.es_error), 0);
                    chk("piso_actual at cambio_piso", piso_actual, e.piso);
                end
            end
            if (cmd_error) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected cmd_error: got pulse expected none (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("event kind at cmd_error", int'(e.es_error), 1);
                    chk("piso_actual at cmd_error", piso_actual, e.piso);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic enviar(input cmd_t c);
        cmd_valid = 1'b1;
        cmd       = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 2'd0;
    endtask

    task automatic paso(input cmd_t c, input int piso_ini);
        int destino;
        destino = (c == SUBIR) ? piso_ini + 1 : piso_ini - 1;
        sb_q.push_back('{es_error: 1'b0, piso: destino});
        enviar(c);
        chk("motor_sub after accept", motor_sub, (c == SUBIR) ? 1 : 0);
        chk("motor_baj after accept", motor_baj, (c == BAJAR) ? 1 : 0);
        chk("cmd_ready in motion", cmd_ready, 0);
        sensor_piso = 1'b1;
        repeat (2) @(negedge clk);
        chk("motor held before cambio", motor_sub | motor_baj, 1);
        chk("no cambio before 3 cycles", cambio_piso, 0);
        @(negedge clk);
        chk("cambio_piso 3 cycles after sensor", cambio_piso, 1);
        chk("motor off at cambio", motor_sub | motor_baj, 0);
        chk("piso after step", piso_actual, destino);
        chk("cmd_ready after step", cmd_ready, 1);
        sensor_piso = 1'b0;
        @(negedge clk);
        chk("cambio_piso one cycle", cambio_piso, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rechazo(input cmd_t c, input int piso);
        sb_q.push_back('{es_error: 1'b1, piso: piso});
        enviar(c);
        chk("cmd_error after reject", cmd_error, 1);
        chk("no motor on reject", motor_sub | motor_baj, 0);
        chk("cmd_ready on reject", cmd_ready, 1);
        @(negedge clk);
        chk("cmd_error one cycle", cmd_error, 0);
        chk("no motor after reject", motor_sub | motor_baj, 0);
        chk("piso unchanged on reject", piso_actual, piso);
    endtask

    initial begin
        int cnt;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd         = 2'd0;
        sensor_piso = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset motors", motor_sub | motor_baj, 0);
        chk("reset puerta", puerta_abierta, 0);
        chk("reset esperar", esperar, 0);
        chk("reset cambio", cambio_piso, 0);
        chk("reset cmd_error", cmd_error, 0);
        chk("reset piso", piso_actual, 0);
        rst = 1'b0;
        @(negedge clk);

        paso(SUBIR, 0);
        paso(SUBIR, 1);
        paso(SUBIR, 2);
        rechazo(SUBIR, 3);
        paso(BAJAR, 3);
        paso(BAJAR, 2);
        paso(BAJAR, 1);
        rechazo(BAJAR, 0);

        enviar(NADA);
        chk("NADA keeps ready", cmd_ready, 1);
        chk("NADA no motor", motor_sub | motor_baj, 0);
        chk("NADA no door", puerta_abierta, 0);
        repeat (2) @(negedge clk);

        // Door dwell, with a sensor pulse during the dwell that must be ignored.
        enviar(ABRIR);
        cnt = 0;
        for (int i = 0; i < TP + 3; i++) begin
            if (puerta_abierta) cnt++;
            if (i < TP) begin
                chk("door open in dwell", puerta_abierta, 1);
                chk("esperar in dwell", esperar, 1);
                chk("cmd_ready in dwell", cmd_ready, 0);
                chk("motors off in dwell", motor_sub | motor_baj, 0);
            end else begin
                chk("door closed after dwell", puerta_abierta, 0);
                chk("esperar low after dwell", esperar, 0);
                chk("cmd_ready after dwell", cmd_ready, 1);
            end
            if (i == 1) sensor_piso = 1'b1;
            if (i == 3) sensor_piso = 1'b0;
            @(negedge clk);
        end
        chk("door cycle count", cnt, TP);
        chk("piso after door spurious edge", piso_actual, 0);

        // Spurious sensor edge while idle.
        sensor_piso = 1'b1;
        repeat (5) @(negedge clk);
        sensor_piso = 1'b0;
        repeat (3) @(negedge clk);
        chk("piso after idle spurious edge", piso_actual, 0);
        chk("ready after idle spurious edge", cmd_ready, 1);

        // Reset in the middle of motion from floor 1.
        paso(SUBIR, 0);
        enviar(SUBIR);
        chk("motor_sub before mid-motion reset", motor_sub, 1);
        sensor_piso = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("motor_sub cleared by reset", motor_sub, 0);
        chk("piso cleared by reset", piso_actual, 0);
        chk("cmd_ready set by reset", cmd_ready, 1);
        chk("no cambio on reset", cambio_piso, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        sensor_piso = 1'b0;
        repeat (3) @(negedge clk);
        chk("piso after reset recovery", piso_actual, 0);

`ifdef EJECUTOR_PISO_WATCHDOG_EN
        chk("falla low before watchdog", falla, 0);
        paso(SUBIR, 0);
        paso(SUBIR, 1);
        enviar(BAJAR);
        for (int i = 0; i < TW; i++) begin
            chk("motor_baj during watchdog window", motor_baj, 1);
            chk("falla low during window", falla, 0);
            @(negedge clk);
        end
        chk("motor_baj off on watchdog", motor_baj, 0);
        chk("falla on watchdog", falla, 1);
        chk("cmd_ready low in FALLA", cmd_ready, 0);
        chk("piso kept in FALLA", piso_actual, 2);
        cmd_valid = 1'b1;
        cmd       = SUBIR;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 2'd0;
        chk("FALLA ignores commands", motor_sub | motor_baj, 0);
        chk("falla sticky", falla, 1);
        chk("cmd_ready still low", cmd_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("falla cleared by reset", falla, 0);
        chk("ready after FALLA reset", cmd_ready, 1);
        chk("piso after FALLA reset", piso_actual, 0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ejecutor_piso.md
Name: ejecutor_piso

Overview:
- Motion and door executor for the elevator car; the plant-side end of the ALGORITMO interface.
- Accepts one-step commands (up one floor, down one floor, open door) derived from the algorithm's estado_final.
- Drives motor and door, tracks the current floor from the shaft sensor.
- Returns the cambio_piso and esperar feedback that ALGORITMO consumes.

Parameters:
- N_PISOS, 4, number of floors; floors are numbered 0..N_PISOS-1.
- T_PUERTA, 50, door dwell time in clk cycles; must be >= 1.
- T_WATCHDOG, 1000, maximum clk cycles in motion without a sensor edge (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd  in  2  command code: 0 NADA, 1 SUBIR, 2 BAJAR, 3 ABRIR.
- cmd_ready  out  1  executor can accept a command.
- sensor_piso  in  1  shaft floor-mark sensor; asynchronous level input.
- motor_sub  out  1  motor drive, up.
- motor_baj  out  1  motor drive, down.
- puerta_abierta  out  1  door open command.
- cambio_piso  out  1  one-cycle pulse when a floor step completes.
- esperar  out  1  high while the door dwell is running.
- piso_actual  out  $clog2(N_PISOS)  current floor.
- cmd_error  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (asynchronous, active-high rst):
  - State REPOSO, piso_actual=0, dwell counter=0.
  - All outputs 0 except cmd_ready=1.
  - Synchronizer flops cleared.
  - Reset asserted mid-motion or mid-dwell aborts immediately; no pulses are emitted.
- sensor_piso input path:
  - 2-flop synchronizer followed by a rising-edge detector.
  - An edge is only acted on in SUBIENDO or BAJANDO; edges in other states are ignored.
- Handshake:
  - A command is accepted on a clk edge where cmd_valid && cmd_ready.
  - cmd_ready=1 only in REPOSO.
  - cmd=NADA is accepted with no effect.
- FSM states: REPOSO, SUBIENDO, BAJANDO, PUERTA.
- REPOSO:
  - SUBIR with piso_actual < N_PISOS-1 -> SUBIENDO.
  - BAJAR with piso_actual > 0 -> BAJANDO.
  - ABRIR -> PUERTA; dwell counter loads T_PUERTA-1.
  - SUBIR at the top floor or BAJAR at floor 0 -> stay in REPOSO; cmd_error pulses in the cycle after acceptance.
- SUBIENDO / BAJANDO:
  - motor_sub (or motor_baj) =1 from the cycle after acceptance.
  - On a detected sensor edge:
    - Next cycle: motor output 0, piso_actual incremented (SUBIENDO) or decremented (BAJANDO), cambio_piso=1 for exactly 1 cycle.
    - State returns to REPOSO.
  - piso_actual never wraps; the range checks at acceptance guarantee this.
- PUERTA:
  - puerta_abierta=1 and esperar=1 for exactly T_PUERTA cycles, then both go to 0 and the state returns to REPOSO.
- Invariants:
  - motor_sub and motor_baj are never high together.
  - Motor is never driven while puerta_abierta=1.
- Latency, accept to motion start: 1 cycle.
- Latency, sensor_piso rising edge to cambio_piso: 3 cycles (2 synchronizer flops + 1 register stage).

Optional Feature:
- Macro: EJECUTOR_PISO_WATCHDOG_EN.
- Defined:
  - A counter runs in SUBIENDO and BAJANDO.
  - If it reaches T_WATCHDOG with no sensor edge: motors go to 0, the FSM enters state FALLA, and output falla=1 (extra 1-bit port).
  - In FALLA, cmd_ready=0; the only exit is rst.
- Not defined:
  - No counter, no FALLA state, no falla port.
  - The executor waits indefinitely for the sensor edge.

Decomposition:
- Package ascensor_pkg holds:
  - the cmd_t enum (NADA/SUBIR/BAJAR/ABRIR);
  - the estado_ejec_t state enum;
  - the default constants N_PISOS_DEF, T_PUERTA_DEF, T_WATCHDOG_DEF.
- The package is shared with ALGORITMO so that command encoding matches on both ends.
- One sub-module, sincronizador_flanco: 2-flop synchronizer plus rising-edge pulse, async reset.

Test Plan:
- Reset mid-motion: rst asserted during SUBIENDO -> motor_sub=0 immediately, piso_actual=0, cmd_ready=1, no cambio_piso pulse.
- Step up: at floor 0, cmd=SUBIR accepted.
  - Next cycle motor_sub=1.
  - Raise sensor_piso; 3 cycles later cambio_piso is a 1-cycle pulse, piso_actual=1, motor_sub=0, cmd_ready=1.
- Boundaries:
  - At floor 3 with N_PISOS=4, SUBIR -> cmd_error pulse, no motor activity.
  - At floor 0, BAJAR -> cmd_error pulse, no motor activity.
- Door dwell: ABRIR with T_PUERTA=5 -> puerta_abierta=esperar=1 for exactly 5 cycles, cmd_ready=0 throughout, motors stay 0.
- Spurious sensor: sensor_piso edge in REPOSO or PUERTA -> piso_actual unchanged, no cambio_piso.
- Watchdog (EJECUTOR_PISO_WATCHDOG_EN defined, T_WATCHDOG=20): BAJAR from floor 2 with no sensor edge -> after 20 cycles motor_baj=0, falla=1, cmd_ready=0 until rst.
